// File: rtl/calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer
//
// Command-level controller for the calculator datapath.
// - It accepts one operation (opcode plus two operands) per cmd valid/ready
//   handshake.
// - It drives the opcode and operands onto the decoder/ALU buses and holds
//   alu_en high for the opcode's execution latency.
// - It then captures the ALU result and presents it on a res valid/ready port.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   cmd_valid   in   command present
//   cmd_ready   out  sequencer can accept a command (IDLE only)
//   cmd_op      in   4-bit opcode
//   cmd_a/b     in   operands
//   alu_op      out  opcode to decoder, stable from accept to next accept
//   alu_en      out  high during the execution window
//   alu_a/b     out  registered operands to ALU
//   alu_result  in   ALU result, sampled on the final execution cycle
//   res_valid   out  result available (DONE)
//   res_ready   in   consumer accepts result
//   res_data    out  captured result
//   res_err     out  divide-by-zero fault flag for this result
//   op_count    out  results handed off, wraps modulo 2^16
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module calc_op_sequencer #(
    parameter int          WIDTH      = 16,
    parameter int          MULTI_LAT  = 4,
    parameter logic [15:0] MULTI_MASK = 16'h0030,
    parameter logic [15:0] DIVZ_MASK  = 16'h0020
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [3:0]       alu_op,
    output logic             alu_en,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] MULTI_CNT = 4'(MULTI_LAT - 1);

    state_t     state_r;
    logic [3:0] cnt_r;
    // Marks a divide-by-zero command. Such a command spends one silent cycle
    // (alu_en low) before DONE, so its result still appears one cycle after accept.
    logic       fault_r;

    logic accept_s;
    logic is_fault_s;
    logic is_multi_s;

    // Accept qualification and per-opcode classification of the incoming command
    always_comb begin
        accept_s   = 1'b0;
        is_fault_s = 1'b0;
        is_multi_s = 1'b0;
        if (state_r == IDLE) begin
            accept_s = cmd_valid & cmd_ready;
        end else begin
            accept_s = 1'b0;
        end
        is_fault_s = DIVZ_MASK[cmd_op] & (cmd_b == {WIDTH{1'b0}});
        is_multi_s = MULTI_MASK[cmd_op];
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            fault_r   <= 1'b0;
            cmd_ready <= 1'b1;
            alu_op    <= 4'd0;
            alu_en    <= 1'b0;
            alu_a     <= {WIDTH{1'b0}};
            alu_b     <= {WIDTH{1'b0}};
            res_valid <= 1'b0;
            res_data  <= {WIDTH{1'b0}};
            res_err   <= 1'b0;
            op_count  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        alu_op    <= cmd_op;
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        cmd_ready <= 1'b0;
                        state_r   <= EXEC;
                        if (is_fault_s) begin
                            // The ALU is never enabled for a faulting command
                            fault_r <= 1'b1;
                            alu_en  <= 1'b0;
                            cnt_r   <= 4'd0;
                        end else begin
                            fault_r <= 1'b0;
                            alu_en  <= 1'b1;
                            cnt_r   <= is_multi_s ? MULTI_CNT : 4'd0;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt_r == 4'd0) begin
                        // Final execution cycle: alu_result is sampled now
                        alu_en    <= 1'b0;
                        res_valid <= 1'b1;
                        state_r   <= DONE;
                        if (fault_r) begin
                            res_data <= {WIDTH{1'b0}};
                            res_err  <= 1'b1;
                        end else begin
                            res_data <= alu_result;
                            res_err  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        cmd_ready <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        res_valid <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle
                    state_r   <= IDLE;
                    alu_en    <= 1'b0;
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
`timescale 1ns/1ps
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  alu_op;
    logic        alu_en;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    calc_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Simple ALU model driven by the sequencer's registered buses
    always_comb begin
        alu_result = 16'd0;
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd4:    alu_result = alu_a * alu_b;
            4'd5:    alu_result = (alu_b != 16'd0) ? alu_a / alu_b : 16'd0;
            4'd15:   alu_result = alu_a ^ alu_b;
            default: alu_result = alu_a - alu_b;
        endcase
    end

    // Issue one command and measure latency / alu_en cycles until res_valid
    task automatic exec_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int en_cnt, output bit op_stable,
                           output bit acc_ok);
        @(negedge clk);
        acc_ok = cmd_ready;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        en_cnt = alu_en ? 1 : 0;
        op_stable = (alu_op === op);
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (alu_en) en_cnt++;
            if (alu_op !== op) op_stable = 1'b0;
        end
    endtask

    // Complete the result handshake
    task automatic handoff();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || alu_en !== 1'b0 || res_valid !== 1'b0 || res_err !== 1'b0 ||
            alu_op !== 4'd0 || alu_a !== 16'd0 || alu_b !== 16'd0 || res_data !== 16'd0 ||
            op_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b en=%b vld=%b err=%b op=%0d a=%0d b=%0d data=%0d cnt=%0d expected rdy=1 rest 0",
                     cmd_ready, alu_en, res_valid, res_err, alu_op, alu_a, alu_b, res_data, op_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_single(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] exp_data, input logic [15:0] exp_cnt);
        int lat; int en; bit st; bit acc;
        exec_op(op, a, b, lat, en, st, acc);
        checks++;
        if (!acc || lat != 1 || en != 1 || !st) begin
            errors++;
            $display("FAIL single_timing op%0d: ready=%b lat=%0d en=%0d stable=%b expected 1/1/1/1", op, acc, lat, en, st);
        end
        checks++;
        if (res_data !== exp_data || res_err !== 1'b0) begin
            errors++;
            $display("FAIL single_data op%0d: got %h err=%b expected %h err=0", op, res_data, res_err, exp_data);
        end
        handoff();
        checks++;
        if (res_valid !== 1'b0 || op_count !== exp_cnt || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_handoff op%0d: vld=%b cnt=%0d rdy=%b expected 0/%0d/1", op, res_valid, op_count, cmd_ready, exp_cnt);
        end
    endtask

    task automatic test_multi(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] exp_data, input logic [15:0] exp_cnt);
        int lat; int en; bit st; bit acc;
        exec_op(op, a, b, lat, en, st, acc);
        checks++;
        if (!acc || lat != 4 || en != 4 || !st) begin
            errors++;
            $display("FAIL multi_timing op%0d: ready=%b lat=%0d en=%0d stable=%b expected 1/4/4/1", op, acc, lat, en, st);
        end
        checks++;
        if (res_data !== exp_data || res_err !== 1'b0) begin
            errors++;
            $display("FAIL multi_data op%0d: got %h err=%b expected %h err=0", op, res_data, res_err, exp_data);
        end
        handoff();
        checks++;
        if (op_count !== exp_cnt) begin
            errors++;
            $display("FAIL multi_count op%0d: got %0d expected %0d", op, op_count, exp_cnt);
        end
    endtask

    task automatic test_divzero();
        int lat; int en; bit st; bit acc;
        exec_op(4'd5, 16'd9, 16'd0, lat, en, st, acc);
        checks++;
        if (lat != 1 || en != 0) begin
            errors++;
            $display("FAIL divz_timing: lat=%0d en=%0d expected 1/0", lat, en);
        end
        checks++;
        if (res_data !== 16'd0 || res_err !== 1'b1) begin
            errors++;
            $display("FAIL divz_result: data=%h err=%b expected 0000/1", res_data, res_err);
        end
        handoff();
        checks++;
        if (op_count !== 16'd4 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL divz_count: cnt=%0d vld=%b expected 4/0", op_count, res_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat; int en; bit st; bit acc; int wait_cnt;
        exec_op(4'd0, 16'd1, 16'd2, lat, en, st, acc);
        // Offer a second command while the first result is stalled
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'd10; cmd_b = 16'd20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 16'd3 || alu_a !== 16'd1) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: rdy=%b vld=%b data=%0d alu_a=%0d expected 0/1/3/1",
                         i, cmd_ready, res_valid, res_data, alu_a);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || alu_a !== 16'd1 || op_count !== 16'd5) begin
            errors++;
            $display("FAIL b2b_idle: rdy=%b alu_a=%0d cnt=%0d expected 1/1/5", cmd_ready, alu_a, op_count);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_a !== 16'd10 || alu_b !== 16'd20 || alu_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: alu_a=%0d alu_b=%0d en=%b expected 10/20/1", alu_a, alu_b, alu_en);
        end
        wait_cnt = 0;
        while (!res_valid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'd30) begin
            errors++;
            $display("FAIL b2b_result: vld=%b data=%0d expected 1/30", res_valid, res_data);
        end
        handoff();
        checks++;
        if (op_count !== 16'd6) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 6", op_count);
        end
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd4; cmd_a = 16'd2; cmd_b = 16'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);           // first EXEC cycle
        @(negedge clk);           // second EXEC cycle
        checks++;
        if (alu_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_exec: alu_en=%b expected 1", alu_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_en !== 1'b0 || res_valid !== 1'b0 || alu_op !== 4'd0 || alu_a !== 16'd0 ||
            alu_b !== 16'd0 || op_count !== 16'd0 || cmd_ready !== 1'b1 || res_data !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_exec: en=%b vld=%b op=%0d a=%0d b=%0d cnt=%0d rdy=%b data=%0d expected all reset",
                     alu_en, res_valid, alu_op, alu_a, alu_b, op_count, cmd_ready, res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_release: rdy=%b vld=%b cnt=%0d expected 1/0/0", cmd_ready, res_valid, op_count);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        #1 release dut.op_count;
        @(negedge clk);
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h expected ffff", op_count);
        end
        test_single(4'd0, 16'd5, 16'd6, 16'd11, 16'd0);
    endtask

    initial begin
        test_reset();
        test_single(4'd0, 16'd3, 16'd4, 16'd7, 16'd1);
        test_multi(4'd4, 16'd6, 16'd7, 16'd42, 16'd2);
        test_multi(4'd5, 16'd20, 16'd3, 16'd6, 16'd3);
        test_divzero();
        test_back_to_back();
        test_reset_mid_exec();
        test_single(4'd15, 16'h00F0, 16'h0FF0, 16'h0F00, 16'd1);
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
